// File: rtl/cp0.sv
// MIPS system-control coprocessor: SR/Cause/EPC/PRId, interrupt and exception
// arbitration for the memory stage, and mfc0/mtc0 access.
module cp0 #(
   parameter logic [31:0] PRID = 32'h0000_1926
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  addr,
   input  logic [31:0] din,
   input  logic        we,
   input  logic        eret,
   input  logic [31:0] pc,
   input  logic        bd,
   input  logic [5:0]  exccode,
   input  logic [5:0]  hwint,
   output logic        intreq,
   output logic [31:0] epc,
   output logic [31:0] dout
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   logic [5:0]  sr_im_q, sr_im_d;
   logic        sr_exl_q, sr_exl_d;
   logic        sr_ie_q, sr_ie_d;
   logic        cause_bd_q, cause_bd_d;
   logic [5:0]  cause_ip_q;
   logic [4:0]  cause_exc_q, cause_exc_d;
   logic [31:0] epc_q, epc_d;

   logic        int_pend;
   logic        exc_pend;
   logic [31:0] epc_target;

   assign int_pend   = (|(hwint & sr_im_q)) & sr_ie_q & ~sr_exl_q;
   assign exc_pend   = (exccode != 6'd0) & ~sr_exl_q;
   assign intreq     = (int_pend | exc_pend) & ~reset;
   assign epc_target = (bd ? (pc - 32'd4) : pc) & 32'hFFFF_FFFC;

   always_comb begin
      sr_im_d     = sr_im_q;
      sr_exl_d    = sr_exl_q;
      sr_ie_d     = sr_ie_q;
      cause_bd_d  = cause_bd_q;
      cause_exc_d = cause_exc_q;
      epc_d       = epc_q;
      if (intreq) begin
         // Taking the trap drops any mtc0/eret sharing this cycle.
         sr_exl_d    = 1'b1;
         cause_bd_d  = bd;
         cause_exc_d = int_pend ? 5'd0 : exccode[4:0];
         epc_d       = epc_target;
      end else begin
         if (we && addr == ADDR_SR) begin
            sr_im_d  = din[15:10];
            sr_exl_d = din[1];
            sr_ie_d  = din[0];
         end
         if (we && addr == ADDR_EPC) begin
            epc_d = din;
         end
         // eret wins over an mtc0 EXL write in the same cycle.
         if (eret) begin
            sr_exl_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im_q     <= 6'd0;
         sr_exl_q    <= 1'b0;
         sr_ie_q     <= 1'b0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= 6'd0;
         cause_exc_q <= 5'd0;
         epc_q       <= 32'd0;
      end else begin
         sr_im_q     <= sr_im_d;
         sr_exl_q    <= sr_exl_d;
         sr_ie_q     <= sr_ie_d;
         cause_bd_q  <= cause_bd_d;
         cause_ip_q  <= hwint;
         cause_exc_q <= cause_exc_d;
         epc_q       <= epc_d;
      end
   end

   assign epc = epc_q;

   always_comb begin
      dout = 32'd0;
      case (addr)
         ADDR_SR:    dout = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
         ADDR_CAUSE: dout = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
         ADDR_EPC:   dout = epc_q;
         ADDR_PRID:  dout = PRID;
         default:    dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: trap entry, priority, EXL masking, eret re-entry,
// register access rules and reset.
module tb_cp0;

   localparam logic [31:0] PRID = 32'h0000_1926;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  addr;
   logic [31:0] din;
   logic        we;
   logic        eret;
   logic [31:0] pc;
   logic        bd;
   logic [5:0]  exccode;
   logic [5:0]  hwint;
   logic        intreq;
   logic [31:0] epc;
   logic [31:0] dout;

   int n_cmp = 0;
   int n_err = 0;

   cp0 #(.PRID(PRID)) dut (
      .clk     (clk),
      .reset   (reset),
      .addr    (addr),
      .din     (din),
      .we      (we),
      .eret    (eret),
      .pc      (pc),
      .bd      (bd),
      .exccode (exccode),
      .hwint   (hwint),
      .intreq  (intreq),
      .epc     (epc),
      .dout    (dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
      addr = a;
      #1;
      check(tag, dout, exp);
   endtask

   task automatic idle();
      we = 1'b0; eret = 1'b0; exccode = 6'd0; din = 32'd0;
   endtask

   initial begin
      reset = 1'b1; addr = 5'd0; din = 32'd0; we = 1'b0; eret = 1'b0;
      pc = 32'd0; bd = 1'b0; exccode = 6'd0; hwint = 6'd0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_intreq", {31'd0, intreq}, 32'd0);
      check("rst_epc", epc, 32'd0);
      rd(5'd12, 32'd0, "rst_sr");
      rd(5'd13, 32'd0, "rst_cause");
      rd(5'd14, 32'd0, "rst_epcreg");
      rd(5'd15, PRID, "rst_prid");

      // 1: timer interrupt
      we = 1'b1; addr = 5'd12; din = 32'h0000_FC01;
      tick(); idle();
      rd(5'd12, 32'h0000_FC01, "t1_sr_wr");
      hwint = 6'b000100; pc = 32'h0000_3010; bd = 1'b0;
      #1;
      check("t1_intreq", {31'd0, intreq}, 32'd1);
      tick(); hwint = 6'd0;
      check("t1_epc", epc, 32'h0000_3010);
      rd(5'd13, 32'h0000_1000, "t1_cause");
      rd(5'd12, 32'h0000_FC03, "t1_sr");

      // eret plus mtc0 SR with EXL=1: EXL cleared, IE taken from din
      eret = 1'b1; we = 1'b1; addr = 5'd12; din = 32'h0000_FC02;
      tick(); idle();
      rd(5'd12, 32'h0000_FC00, "eret_mtc0_sr");

      // 2: exception in delay slot, IE=0
      exccode = 6'd12; pc = 32'h0000_3024; bd = 1'b1;
      #1;
      check("t2_intreq", {31'd0, intreq}, 32'd1);
      tick(); idle(); bd = 1'b0;
      check("t2_epc", epc, 32'h0000_3020);
      rd(5'd13, 32'h8000_0030, "t2_cause");

      // 3: interrupt beats exception, concurrent mtc0 EPC dropped
      we = 1'b1; addr = 5'd12; din = 32'h0000_0401;
      tick(); idle();
      hwint = 6'b000001; exccode = 6'd4; pc = 32'h0000_3040;
      we = 1'b1; addr = 5'd14; din = 32'hDEAD_BEEC;
      #1;
      check("t3_intreq", {31'd0, intreq}, 32'd1);
      tick(); idle(); hwint = 6'd0;
      check("t3_epc", epc, 32'h0000_3040);
      rd(5'd13, 32'h0000_0400, "t3_cause");
      rd(5'd12, 32'h0000_0403, "t3_sr");

      // 4: EXL masks everything; eret then re-entry
      exccode = 6'd10; hwint = 6'h3F; pc = 32'h0000_5000;
      #1;
      check("t4_masked", {31'd0, intreq}, 32'd0);
      tick(); idle();
      check("t4_epc_hold", epc, 32'h0000_3040);
      rd(5'd12, 32'h0000_0403, "t4_sr_hold");
      rd(5'd13, 32'h0000_FC00, "t4_cause_ip");
      eret = 1'b1;
      #1;
      check("t4_eret_cyc", {31'd0, intreq}, 32'd0);
      tick(); idle(); pc = 32'h0000_6000;
      rd(5'd12, 32'h0000_0401, "t4_sr_exl0");
      check("t4_reentry", {31'd0, intreq}, 32'd1);
      tick(); hwint = 6'd0;
      check("t4_epc_re", epc, 32'h0000_6000);

      // 5: Cause read-only, PRId, unmapped, no write bypass
      we = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF;
      tick(); idle();
      rd(5'd13, 32'h0000_0000, "t5_cause_ro");
      rd(5'd15, PRID, "t5_prid");
      we = 1'b1; addr = 5'd7; din = 32'h1234_5678;
      tick(); idle();
      rd(5'd7, 32'd0, "t5_unmapped");
      we = 1'b1; addr = 5'd14; din = 32'h0000_4180;
      #1;
      check("t5_no_bypass", dout, 32'h0000_6000);
      tick(); idle();
      check("t5_epc_wr", epc, 32'h0000_4180);

      // 6: reset in handler
      rd(5'd12, 32'h0000_0403, "t6_pre_sr");
      reset = 1'b1; exccode = 6'd5;
      #1;
      check("t6_intreq_rst", {31'd0, intreq}, 32'd0);
      tick(); reset = 1'b0; exccode = 6'd0;
      check("t6_epc", epc, 32'd0);
      rd(5'd12, 32'd0, "t6_sr");
      rd(5'd13, 32'd0, "t6_cause");
      rd(5'd14, 32'd0, "t6_epcreg");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cp0.md
# cp0

System-control coprocessor that sits directly beside the memory stage of the pipelined MIPS core. It collects the memory-stage macro state: PC, branch-delay flag and pending exception code. It also samples the six external hardware-interrupt lines. From these it decides, each cycle, whether the pipeline must be flushed to the handler, and returns `intreq`, the exception return address `epc`, and `mfc0` read data to the datapath.

## Interface

Parameters:
- `PRID`, default 32'h0000_1926: constant value returned by PRId (reg 15).

Ports:
- `clk`  in  1: core clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `addr`  in  5: CP0 register number for both `mfc0` read and `mtc0` write (instr_m[15:11]).
- `din`  in  32: `mtc0` write data (forwarded rt value of the memory-stage instruction).
- `we`  in  1: `mtc0` write enable, memory stage.
- `eret`  in  1: `eret` is in the memory stage.
- `pc`  in  32: macro PC of the oldest valid instruction (memory stage first).
- `bd`  in  1: macro branch-delay flag matching `pc`.
- `exccode`  in  6: pending exception code from the memory stage; 0 means none.
- `hwint`  in  6: external interrupt lines, level-sensitive; bit 2 is the timer.
- `intreq`  out  1: take exception/interrupt this cycle (combinational).
- `epc`  out  32: current EPC register value.
- `dout`  out  32: read data for `addr` (combinational).

## Operation

Registers (unlisted bits read 0):
- SR (12): IM = bits [15:10], EXL = bit [1], IE = bit [0].
- Cause (13): BD = bit [31], IP = bits [15:10], ExcCode = bits [6:2]. Cause is read-only to `mtc0`.
- EPC (14): 32 bits, read/write.
- PRId (15): `PRID`, read-only.
- Any other `addr` reads 32'h0; writes to it are ignored.

Request logic:
- `int_pend = |(hwint & SR.IM) & SR.IE & ~SR.EXL`.
- `exc_pend = (exccode != 0) & ~SR.EXL`.
- `intreq = (int_pend | exc_pend) & ~reset`.
- Interrupt has priority over a simultaneous exception.

On a cycle with `intreq`=1, at the next edge:
- SR.EXL ← 1.
- Cause.BD ← `bd`.
- Cause.ExcCode ← 0 if `int_pend`, otherwise `exccode[4:0]`.
- EPC ← (`bd` ? `pc` − 4 : `pc`) & 32'hFFFF_FFFC.
- Any concurrent `we` or `eret` is discarded.

Otherwise:
- `eret`=1 → SR.EXL ← 0.
- `we`=1 with `addr`=12 → SR.IM ← din[15:10], SR.EXL ← din[1], SR.IE ← din[0].
- `we`=1 with `addr`=14 → EPC ← din.
- If `eret` and an `mtc0` to SR occur in the same cycle, `eret` clears EXL and the `mtc0` updates IM/IE only.

Cause.IP ← `hwint` every cycle unconditionally, including during `intreq`.

Exceptions raised while EXL=1 are ignored: no state change and `intreq`=0.

## Timing

- Reset: SR, Cause and EPC are all 0. `intreq`=0 throughout the reset cycle. `dout` reads 0 for every register except PRId.
- `intreq` is combinational in the same cycle as the triggering `exccode`/`hwint`. Datapath flush and NPC redirect happen on that same edge.
- Register updates are visible on `dout`/`epc` one cycle after the triggering edge. There is no write-through bypass: `mfc0` in the cycle of an `mtc0` to the same register reads the old value.
- Cause.IP reflects `hwint` with one cycle of delay. `int_pend` uses live `hwint`, not IP.
- With `hwint` held high, after `eret` clears EXL, `intreq` reasserts in the next cycle (re-entry is intended).
- Reset asserted mid-handler (EXL=1) returns every register to 0 on that edge.

## Test plan

1. Reset, then `mtc0` SR=32'h0000_FC01, then `hwint`=6'b000100 with `pc`=32'h0000_3010, `bd`=0:
   - `intreq`=1 in the same cycle.
   - Next cycle: EPC=32'h0000_3010, Cause=32'h0000_1000 (IP bit 12 set), SR=32'h0000_FC03.
2. Exception `exccode`=12, `pc`=32'h0000_3024, `bd`=1, IE=0:
   - `intreq`=1 (exceptions are not masked by IE).
   - Next cycle: EPC=32'h0000_3020, Cause=32'h8000_0030.
3. Interrupt and exception together, IE=1, IM[10]=1, `hwint`[0]=1, `exccode`=4:
   - Cause.ExcCode=0.
   - A concurrent `mtc0` EPC=32'hDEAD_BEEC is dropped.
4. EXL=1, `exccode`=10 and `hwint`=6'h3F:
   - `intreq`=0; SR/EPC unchanged.
   - `eret` → EXL=0 next cycle, and `intreq`=1 the cycle after with `hwint` still high.
5. `mtc0` to Cause (addr 13) with din=32'hFFFF_FFFF:
   - Cause unchanged.
   - `mfc0` 15 returns `PRID`; `mfc0` 7 returns 0.
6. Reset asserted while EXL=1 and EPC=32'h0000_4180:
   - All registers 0 next cycle.
   - `intreq`=0 during reset even with `exccode`≠0.
